// File: rtl/decode_stage_reg_if.sv
// Handshake and decoded-field bundle between fetch, the IF/ID stage and execute.
// master = fetch/execute side, slave = the decode stage register.
interface decode_stage_reg_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instruction;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            illegal;

    modport master (
        output in_valid, in_instruction, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2,
               funct7, imm, imm_type, illegal
    );

    modport slave (
        input  in_valid, in_instruction, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2,
               funct7, imm, imm_type, illegal
    );
endinterface

// File: rtl/decode_stage_reg.sv
// IF/ID stage register: decodes on entry, holds up to two entries (skid) or one,
// and drives every output straight from the main register.
module decode_stage_reg #(
    parameter int XLEN        = 32,
    parameter bit ENABLE_SKID = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    decode_stage_reg_if.slave  bus
);
    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            ill;
    } dec_t;

    dec_t        r_main, r_skid, w_dec;
    logic        r_main_vld, r_skid_vld;
    logic        w_in_ready, w_acc;
    logic [31:0] w_ins, w_imm32;
    logic [2:0]  w_typ;
    logic        w_ill;

    assign w_ins = bus.in_instruction;

    always_comb begin
        w_typ = T_NONE;
        w_ill = 1'b0;
        unique case (w_ins[6:0])
            7'b0110011:                                         w_typ = T_NONE;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:                             w_typ = T_I;
            7'b0100011:                                         w_typ = T_S;
            7'b1100011:                                         w_typ = T_B;
            7'b0110111, 7'b0010111:                             w_typ = T_U;
            7'b1101111:                                         w_typ = T_J;
            default:                                            w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_imm32 = '0;
        unique case (w_typ)
            T_I:     w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
            T_S:     w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            T_B:     w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
            T_U:     w_imm32 = {w_ins[31:12], 12'b0};
            T_J:     w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // The 32-bit immediate already carries its sign in bit 31; widen from there.
    always_comb begin
        w_dec          = '0;
        w_dec.pc       = bus.in_pc;
        w_dec.instr    = w_ins;
        w_dec.typ      = w_typ;
        w_dec.ill      = w_ill;
        w_dec.imm      = {XLEN{w_imm32[31]}};
        w_dec.imm[31:0] = w_imm32;
    end

    assign w_in_ready = ENABLE_SKID ? ~r_skid_vld : (bus.out_ready | ~r_main_vld);
    assign w_acc      = bus.in_valid & w_in_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (bus.flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (ENABLE_SKID) begin
            if (!r_main_vld || bus.out_ready) begin
                if (r_skid_vld) begin
                    r_main     <= r_skid;
                    r_main_vld <= 1'b1;
                    r_skid_vld <= w_acc;
                    if (w_acc) r_skid <= w_dec;
                end else begin
                    r_main_vld <= w_acc;
                    if (w_acc) r_main <= w_dec;
                end
            end else if (w_acc) begin
                r_skid     <= w_dec;
                r_skid_vld <= 1'b1;
            end
        end else begin
            if (w_acc) begin
                r_main     <= w_dec;
                r_main_vld <= 1'b1;
            end else if (bus.out_ready) begin
                r_main_vld <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_main_vld;
    assign bus.out_pc    = r_main.pc;
    assign bus.opcode    = r_main.instr[6:0];
    assign bus.rd        = r_main.instr[11:7];
    assign bus.funct3    = r_main.instr[14:12];
    assign bus.rs1       = r_main.instr[19:15];
    assign bus.rs2       = r_main.instr[24:20];
    assign bus.funct7    = r_main.instr[31:25];
    assign bus.imm       = r_main.imm;
    assign bus.imm_type  = r_main.typ;
    // Stale data after a flush must never report as illegal.
    assign bus.illegal   = r_main.ill & r_main_vld;
endmodule

// File: tb/tb_decode_stage_reg.sv
// Bench: 32-bit skid instance and 64-bit single-register instance driven in lockstep,
// each compared against a queue-based occupancy model and a field-rule decoder.
module tb_decode_stage_reg;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_reg_if #(.XLEN(32)) b32 ();
    decode_stage_reg_if #(.XLEN(64)) b64 ();

    decode_stage_reg #(.XLEN(32), .ENABLE_SKID(1'b1)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
    decode_stage_reg #(.XLEN(64), .ENABLE_SKID(1'b0)) u64 (.clk(clk), .reset(reset), .bus(b64.slave));

    typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
    typedef struct { logic [63:0] imm; logic [2:0] typ; logic ill; } exp_t;

    ent_t q32[$];
    ent_t q64[$];
    int   errors = 0;
    int   checks = 0;
    logic cur_ordy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] ins);
        exp_t   e;
        longint v;
        e.typ = 3'd0; e.ill = 1'b0; v = 0;
        case (ins[6:0])
            7'h33: ;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
                e.typ = 3'd1; v = ins[31:20]; if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                e.typ = 3'd2; v = {ins[31:25], ins[11:7]}; if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                e.typ = 3'd3; v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: begin
                e.typ = 3'd4; v = ins & 32'hFFFFF000; if (v >= 64'h8000_0000) v -= 64'h1_0000_0000;
            end
            7'h6F: begin
                e.typ = 3'd5; v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; if (v >= 64'h10_0000) v -= 64'h20_0000;
            end
            default: e.ill = 1'b1;
        endcase
        e.imm = v;
        return e;
    endfunction

    task automatic check_all();
        exp_t e;
        chk("rdy32", b32.in_ready, q32.size() < 2);
        chk("vld32", b32.out_valid, q32.size() > 0);
        if (q32.size() > 0) begin
            e = ref_dec(q32[0].ins);
            chk("pc32", b32.out_pc, q32[0].pc[31:0]);
            chk("op32", b32.opcode, q32[0].ins[6:0]);
            chk("rd32", b32.rd, q32[0].ins[11:7]);
            chk("f3_32", b32.funct3, q32[0].ins[14:12]);
            chk("rs1_32", b32.rs1, q32[0].ins[19:15]);
            chk("rs2_32", b32.rs2, q32[0].ins[24:20]);
            chk("f7_32", b32.funct7, q32[0].ins[31:25]);
            chk("imm32", b32.imm, e.imm[31:0]);
            chk("typ32", b32.imm_type, e.typ);
            chk("ill32", b32.illegal, e.ill);
        end else chk("ill32_idle", b32.illegal, 1'b0);
        chk("rdy64", b64.in_ready, cur_ordy | (q64.size() == 0));
        chk("vld64", b64.out_valid, q64.size() > 0);
        if (q64.size() > 0) begin
            e = ref_dec(q64[0].ins);
            chk("pc64", b64.out_pc, q64[0].pc);
            chk("op64", b64.opcode, q64[0].ins[6:0]);
            chk("rs1_64", b64.rs1, q64[0].ins[19:15]);
            chk("imm64", b64.imm, e.imm);
            chk("typ64", b64.imm_type, e.typ);
            chk("ill64", b64.illegal, e.ill);
        end else chk("ill64_idle", b64.illegal, 1'b0);
    endtask

    // One clock: drive, advance the model, clock, then compare.
    task automatic cyc(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                       input bit ordy, input bit fl, input bit rst);
        ent_t n;
        bit   rdy;
        reset = rst;
        b32.in_valid = v; b32.in_instruction = ins; b32.in_pc = pc[31:0];
        b32.out_ready = ordy; b32.flush = fl;
        b64.in_valid = v; b64.in_instruction = ins; b64.in_pc = pc;
        b64.out_ready = ordy; b64.flush = fl;
        cur_ordy = ordy;
        n.pc = pc; n.ins = ins;
        if (rst || fl) begin
            q32.delete(); q64.delete();
        end else begin
            rdy = q32.size() < 2;
            if (ordy && q32.size() > 0) void'(q32.pop_front());
            if (v && rdy) q32.push_back(n);
            rdy = ordy || q64.size() == 0;
            if (ordy && q64.size() > 0) void'(q64.pop_front());
            if (v && rdy) q64.push_back(n);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        cyc(1'b1, ins, pc, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, 32'h0, 64'h0, ordy, 1'b0, 1'b0);
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_pc"}, b32.out_pc, 0);
        chk({tag, "_op"}, b32.opcode, 0);
        chk({tag, "_rd"}, b32.rd, 0);
        chk({tag, "_f3"}, b32.funct3, 0);
        chk({tag, "_rs1"}, b32.rs1, 0);
        chk({tag, "_rs2"}, b32.rs2, 0);
        chk({tag, "_f7"}, b32.funct7, 0);
        chk({tag, "_imm"}, b32.imm, 0);
        chk({tag, "_typ"}, b32.imm_type, 0);
        chk({tag, "_ill"}, b32.illegal, 0);
        chk({tag, "_vld"}, b32.out_valid, 0);
        chk({tag, "_rdy"}, b32.in_ready, 1);
        chk({tag, "_pc64"}, b64.out_pc, 0);
        chk({tag, "_imm64"}, b64.imm, 0);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                                 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 5) != 0) w[6:0] = ops[$urandom_range(0, 11)];
        return w;
    endfunction

    initial begin
        logic [63:0] pc;
        reset = 1'b1; cur_ordy = 1'b0;
        b32.in_valid = 0; b32.in_instruction = 0; b32.in_pc = 0; b32.out_ready = 0; b32.flush = 0;
        b64.in_valid = 0; b64.in_instruction = 0; b64.in_pc = 0; b64.out_ready = 0; b64.flush = 0;
        cyc(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        zero_outputs("rst");

        // addi x1,x2,-1
        send(32'hFFF10093, 64'h100);
        chk("addi_op", b32.opcode, 7'h13);
        chk("addi_rd", b32.rd, 1);
        chk("addi_rs1", b32.rs1, 2);
        chk("addi_imm", b32.imm, 32'hFFFFFFFF);
        chk("addi_typ", b32.imm_type, 1);
        chk("addi_pc", b32.out_pc, 32'h100);
        chk("addi_imm64", b64.imm, 64'hFFFFFFFFFFFFFFFF);

        send(32'h00512423, 64'h104);
        chk("sw_imm", b32.imm, 8);
        chk("sw_typ", b32.imm_type, 2);
        chk("sw_rs2", b32.rs2, 5);
        chk("sw_f3", b32.funct3, 2);
        send(32'hFE000EE3, 64'h108);
        chk("beq_imm", b32.imm, 32'hFFFFFFFC);
        chk("beq_typ", b32.imm_type, 3);
        send(32'h123451B7, 64'h10C);
        chk("lui_imm", b32.imm, 32'h12345000);
        chk("lui_typ", b32.imm_type, 4);
        send(32'h0010006F, 64'h110);
        chk("jal_imm", b32.imm, 32'h00000800);
        chk("jal_typ", b32.imm_type, 5);
        idle(1'b1);

        // Backpressure: PCs 0,4,8,12 offered while execute stalls.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h00000013, 64'(i * 4), 1'b0, 1'b0, 1'b0);
        chk("bp_rdy", b32.in_ready, 0);
        chk("bp_head", b32.out_pc, 0);
        cyc(1'b1, 32'h00000013, 64'd16, 1'b1, 1'b0, 1'b0);
        chk("bp_next", b32.out_pc, 4);
        for (int i = 5; i < 8; i++) cyc(1'b1, 32'h00000013, 64'(i * 4), 1'b1, 1'b0, 1'b0);
        idle(1'b1); idle(1'b1);

        // Flush with both entries held plus a concurrent input.
        cyc(1'b1, 32'h00100093, 64'h200, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h00200093, 64'h204, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h00300093, 64'h208, 1'b0, 1'b1, 1'b0);
        chk("fl_vld", b32.out_valid, 0);
        chk("fl_rdy", b32.in_ready, 1);
        idle(1'b1);

        // Illegal encodings.
        send(32'h00000000, 64'h300);
        chk("zero_ill", b32.illegal, 1);
        chk("zero_typ", b32.imm_type, 0);
        send(32'h0000007F, 64'h304);
        chk("7f_ill", b32.illegal, 1);
        chk("7f_imm", b32.imm, 0);
        idle(1'b1);

        // Reset mid-stream with two entries held.
        cyc(1'b1, 32'h00512423, 64'h400, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hFE000EE3, 64'h404, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h123451B7, 64'h408, 1'b0, 1'b0, 1'b1);
        zero_outputs("mrst");
        send(32'hFFF10093, 64'h500);
        chk("post_imm", b32.imm, 32'hFFFFFFFF);
        chk("post_pc", b32.out_pc, 32'h500);

        // Randomised traffic.
        pc = 64'h1000;
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 3) != 0, rand_ins(), pc,
                $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
            pc += 4;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage_reg.md
Name: decode_stage_reg

Overview:
- Pipelined IF/ID decode stage for the RISC-V pipeline.
- Registers each fetched instruction with its PC, splits it into opcode/rd/funct3/rs1/rs2/funct7, generates the sign-extended immediate, and flags illegal encodings.
- Uses a valid/ready handshake with an optional 2-entry skid buffer, so fetch and execute can stall independently.
- Supports flush for branch redirect.

Parameters:
- XLEN, 32, datapath width of pc and imm; legal values 32 or 64.
- ENABLE_SKID, 1: 1 = 2-entry skid buffer with fully registered in_ready; 0 = single register with in_ready = out_ready | ~out_valid.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instruction  input  32  raw instruction word.
- in_pc  input  XLEN  PC of in_instruction.
- flush  input  1  discard all held instructions.
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  execute stage accepts.
- out_pc  output  XLEN  PC of the output instruction.
- opcode  output  7  instr[6:0].
- rd  output  5  instr[11:7].
- funct3  output  3  instr[14:12].
- rs1  output  5  instr[19:15].
- rs2  output  5  instr[24:20].
- funct7  output  7  instr[31:25].
- imm  output  XLEN  sign-extended immediate; 0 when imm_type = NONE.
- imm_type  output  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
- illegal  output  1  out_valid & unrecognised encoding.

Behaviour:
- Decoding happens on entry and the decoded fields are stored. All outputs are driven directly from registers, with no combinational path from in_* to out_*.
- Reset (synchronous, active-high): valid bits cleared; every output register is 0, including out_pc, all fields, imm, imm_type (NONE) and illegal. in_ready = 1 in the first cycle after reset deasserts.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Latency is 1 cycle: an instruction accepted at edge N is presented at out_* after edge N.
- Skid mode (ENABLE_SKID = 1):
  - Main register feeds the outputs; the skid register holds one extra entry. in_ready = ~skid_valid (registered).
  - If an input is accepted while main is valid and not draining, the input goes to skid.
  - When main drains and skid is valid, skid moves to main that cycle; a new input is then accepted into skid if in_ready.
  - Order is strictly preserved and no instruction is lost or duplicated.
- Non-skid mode (ENABLE_SKID = 0): single register; in_ready = out_ready | ~out_valid (combinational from out_ready).
- Simultaneous drain and accept with main valid and skid empty: main takes the new entry; out_valid stays 1.
- Flush:
  - Both valid bits clear at the next edge.
  - Overrides any same-cycle accept: the input is dropped even if in_valid & in_ready.
  - The output transfer in the flush cycle still counts if out_ready.
  - Data registers may keep stale contents; illegal is gated to 0.
- Reset has priority over flush and over the handshakes. Reset mid-stream discards all held entries.
- Immediate generation: all forms are sign-extended from instr[31] to XLEN.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}; sign-extended to XLEN when XLEN = 64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Opcode to imm_type mapping:
  - 0110011 → NONE.
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
- Illegal:
  - Set when instr[1:0] != 2'b11 or the opcode is not in the list above. The word is still passed through with imm_type = NONE and imm = 0.
  - 32'h00000000 is illegal.

Test Plan:
- addi x1,x2,-1 (0xFFF10093) with out_ready = 1 → next cycle: opcode 0x13, rd 1, funct3 0, rs1 2, imm 0xFFFFFFFF, imm_type 1, illegal 0; out_pc equals in_pc.
- Back-to-back stream: sw x5,8(x2) (0x00512423) → imm 8, type S, rs1 2, rs2 5, funct3 2. Then beq x0,x0,-4 (0xFE000EE3) → imm 0xFFFFFFFC, type B. Then lui x3,0x12345 (0x123451B7) → imm 0x12345000, type U. Then jal x0,+2048 (0x0010006F) → imm 0x00000800, type J.
- Backpressure (ENABLE_SKID = 1): hold out_ready = 0 for 4 cycles while in_valid = 1 with PCs 0,4,8,… → exactly 2 accepted and in_ready = 0 from the cycle after the second accept. On release, outputs appear as PC 0 then 4 on consecutive cycles, then streaming resumes with no loss.
- Flush with both entries valid plus a concurrent in_valid → next cycle out_valid = 0, in_ready = 1; the flushed-cycle input never appears at the output.
- Illegal encodings: inputs 0x00000000 and 0x0000007F → illegal = 1, imm_type 0, imm 0. Repeat with XLEN = 64 on 0xFFF10093 → imm 0xFFFFFFFFFFFFFFFF.
- Assert reset for one cycle mid-stream with 2 entries held → all outputs 0 and out_valid = 0 on the following cycle; the first instruction after reset is decoded correctly with 1-cycle latency.
